// File: rtl/sat_div_16bit.sv
// Serial restoring signed divider with saturated quotient and a start/busy/done handshake.
// Optional unsigned mode (extra `uns` input) is enabled by defining SAT_DIV_UNSIGNED_EN.
module sat_div_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SAT_DIV_UNSIGNED_EN
  input  logic             uns,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             Ovfl,
  output logic             DivZ
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int               CNT_W   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               uns_in;
  logic               sign_a_in, sign_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;

  // Working registers: remainder is WIDTH+1 bits so a 0x8000 magnitude never wraps.
  logic [WIDTH:0]     rem_r;
  logic [WIDTH-1:0]   quot_r;
  logic [WIDTH-1:0]   mag_b;
  logic               sign_a, sign_q, divz_r, uns_r;

  logic [WIDTH+1:0]        shifted;
  logic signed [WIDTH+1:0] trial;
  logic                    trial_neg;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Only a positive 2^(WIDTH-1) magnitude (min / -1) cannot be represented.
  function automatic logic [WIDTH-1:0] sat_quot(input logic [WIDTH-1:0] mag, input logic neg);
    if (!neg && mag[WIDTH-1]) return SAT_MAX;
    return apply_sign(mag, neg);
  endfunction

`ifdef SAT_DIV_UNSIGNED_EN
  assign uns_in = uns;
`else
  assign uns_in = 1'b0;
`endif

  assign sign_a_in = A[WIDTH-1] & ~uns_in;
  assign sign_b_in = B[WIDTH-1] & ~uns_in;
  assign mag_a_in  = apply_sign(A, sign_a_in);
  assign mag_b_in  = apply_sign(B, sign_b_in);

  assign shifted   = {rem_r, quot_r[WIDTH-1]};
  assign trial     = $signed(shifted) - $signed({2'b00, mag_b});
  assign trial_neg = trial[WIDTH+1];

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (B == '0) ? FIN : CALC;
      CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      quot_r <= mag_a_in;
      rem_r  <= '0;
      mag_b  <= mag_b_in;
      sign_a <= sign_a_in;
      sign_q <= sign_a_in ^ sign_b_in;
      divz_r <= (B == '0);
      uns_r  <= uns_in;
    end else if (state_q == CALC) begin
      rem_r  <= trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
      quot_r <= {quot_r[WIDTH-2:0], ~trial_neg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
      Quot    <= '0;
      Rem     <= '0;
      Ovfl    <= 1'b0;
      DivZ    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == FIN);
      cnt_q   <= (state_q == CALC) ? cnt_q + 1'b1 : '0;
      // Sign correction and result write-back
      if (state_q == FIN) begin
        if (divz_r) begin
          Quot <= uns_r ? {WIDTH{1'b1}} : (sign_a ? SAT_MIN : SAT_MAX);
          Rem  <= apply_sign(quot_r, sign_a);
          Ovfl <= 1'b0;
          DivZ <= 1'b1;
        end else begin
          Quot <= uns_r ? quot_r : sat_quot(quot_r, sign_q);
          Rem  <= apply_sign(rem_r[WIDTH-1:0], sign_a);
          Ovfl <= ~uns_r & ~sign_q & quot_r[WIDTH-1];
          DivZ <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sat_div_16bit.sv
// Directed bench for sat_div_16bit: vector table plus handshake and reset sequences.
module tb_sat_div_16bit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] A, B;
  logic        busy, done, Ovfl, DivZ;
  logic [15:0] Quot, Rem;
`ifdef SAT_DIV_UNSIGNED_EN
  logic        uns = 1'b0;
`endif

  sat_div_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
`ifdef SAT_DIV_UNSIGNED_EN
    .uns(uns),
`endif
    .busy(busy), .done(done), .Quot(Quot), .Rem(Rem), .Ovfl(Ovfl), .DivZ(DivZ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        ov, dz;
  } vec_t;

  vec_t tbl[14];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int j = 0;
    int bc = 0;
    while (!done && j < 64) begin
      if (busy) bc++;
      @(negedge clk);
      j++;
    end
    chk({name, " latency"}, j, exp_lat);
    chk({name, " busy cycles"}, bc, exp_busy);
  endtask

  task automatic chk_res(input string name, input vec_t v);
    chk({name, " Quot"}, {16'h0, Quot}, {16'h0, v.q});
    chk({name, " Rem"},  {16'h0, Rem},  {16'h0, v.r});
    chk({name, " Ovfl"}, {31'h0, Ovfl}, {31'h0, v.ov});
    chk({name, " DivZ"}, {31'h0, DivZ}, {31'h0, v.dz});
  endtask

  task automatic chk_zero(input string name);
    chk({name, " busy"}, {31'h0, busy}, 32'h0);
    chk({name, " done"}, {31'h0, done}, 32'h0);
    chk({name, " Quot"}, {16'h0, Quot}, 32'h0);
    chk({name, " Rem"},  {16'h0, Rem},  32'h0);
    chk({name, " Ovfl"}, {31'h0, Ovfl}, 32'h0);
    chk({name, " DivZ"}, {31'h0, DivZ}, 32'h0);
  endtask

  initial begin
    vec_t v;
    int   quiet;
    tbl[0]  = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0};
    tbl[1]  = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
    tbl[2]  = '{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
    tbl[3]  = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{16'h1234, 16'h0000, 16'h7FFF, 16'h1234, 1'b0, 1'b1};
    tbl[7]  = '{16'hF000, 16'h0000, 16'h8000, 16'hF000, 1'b0, 1'b1};
    tbl[8]  = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{16'h0003, 16'h0007, 16'h0000, 16'h0003, 1'b0, 1'b0};
    tbl[10] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0};
    tbl[12] = '{16'hFFFF, 16'h0002, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    tbl[13] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      start_op(tbl[i].a, tbl[i].b);
      wait_done($sformatf("vec%0d", i), tbl[i].dz ? 1 : 17, tbl[i].dz ? 1 : 17);
      chk_res($sformatf("vec%0d", i), tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse width", i), {31'h0, done}, 32'h0);
    end

    // start re-asserted while busy with new operands must be ignored
    start_op(16'h0064, 16'h0007);
    repeat (5) @(negedge clk);
    A = 16'h1234; B = 16'h0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy-start", 11, 11);
    chk_res("busy-start", tbl[0]);
    @(negedge clk);
    chk("busy-start no recapture", {31'h0, busy}, 32'h0);

    // start in the done cycle is accepted; old outputs hold until next FIN
    start_op(16'hFF9C, 16'h0007);
    wait_done("back2back first", 17, 17);
    chk_res("back2back first", tbl[1]);
    start_op(16'h8000, 16'hFFFF);
    chk("back2back hold Quot", {16'h0, Quot}, 32'h0000FFF2);
    wait_done("back2back second", 17, 17);
    chk_res("back2back second", tbl[4]);
    @(negedge clk);

    // reset at iteration 8 aborts without a done pulse
    start_op(16'h0064, 16'h0007);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mid-reset");
    quiet = 1;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) quiet = 0;
      @(negedge clk);
    end
    chk("mid-reset no done", quiet, 1);
    v = tbl[0];
    start_op(v.a, v.b);
    wait_done("post-reset", 17, 17);
    chk_res("post-reset", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
